// File: rtl/dsi_pixel_fetcher.sv
// Frame/line pixel fetcher: runs the source frame handshake, pulls 24-bit pixels
// through a 2-entry skid buffer and serialises them as an R,G,B byte stream.
module dsi_pixel_fetcher #(
    parameter int unsigned g_size_width = 12,
    parameter int unsigned g_buf_depth  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic [g_size_width-1:0] h_size_i,
    input  logic [g_size_width-1:0] v_size_i,
    input  logic                    frame_start_i,
    input  logic                    line_req_i,
    input  logic                    fifo_empty_i,
    output logic                    fifo_rd_o,
    input  logic [23:0]             fifo_pixels_i,
    output logic                    pix_next_frame_o,
    input  logic                    pix_vsync_i,
    output logic [7:0]              byte_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    line_done_o,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SYNC,
        ST_LWAIT,
        ST_FETCH
    } state_t;

    localparam logic [g_size_width-1:0] size_one = g_size_width'(1);
    localparam logic [1:0]              buf_lim  = 2'(g_buf_depth);

    state_t                  state_q, state_d;
    logic [g_size_width-1:0] h_size_q, h_size_d;
    logic [g_size_width-1:0] v_size_q, v_size_d;
    logic [g_size_width-1:0] ycnt_q, ycnt_d;
    logic [g_size_width-1:0] rd_left_q, rd_left_d;
    logic [g_size_width-1:0] pix_left_q, pix_left_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    inflight_q, inflight_d;
    logic [23:0]             buf_q [g_buf_depth];

    logic [23:0]             head_pix;
    logic [g_size_width-1:0] ycnt_inc;
    logic                    in_fetch;
    logic                    byte_valid;
    logic                    fire;
    logic                    pop;
    logic                    last_pop;
    logic                    rd_en;
    logic                    push;

    assign in_fetch   = enable_i && (state_q == ST_FETCH);
    assign head_pix   = buf_q[rd_ptr_q];
    assign byte_valid = in_fetch && (cnt_q != 2'd0);
    assign fire       = byte_valid && byte_ready_i;
    assign pop        = fire && (byte_idx_q == 2'd2);
    assign last_pop   = pop && (pix_left_q == size_one);
    assign ycnt_inc   = ycnt_q + size_one;
    assign push       = inflight_q;
    // The in-flight read reserves a buffer slot so captured data always has room.
    assign rd_en      = in_fetch && !fifo_empty_i && (rd_left_q != '0)
                        && ((cnt_q + {1'b0, inflight_q}) < buf_lim);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d    = state_q;
        h_size_d   = h_size_q;
        v_size_d   = v_size_q;
        ycnt_d     = ycnt_q;
        rd_left_d  = rd_left_q;
        pix_left_d = pix_left_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
        inflight_d = rd_en;

        if (rd_en) rd_left_d = rd_left_q - size_one;
        if (pop) pix_left_d = pix_left_q - size_one;
        if (fire) byte_idx_d = (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_i && (h_size_i != '0) && (v_size_i != '0)) begin
                    h_size_d = h_size_i;
                    v_size_d = v_size_i;
                    ycnt_d   = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ:   if (pix_vsync_i) state_d = ST_SYNC;
            ST_SYNC:  if (!pix_vsync_i) state_d = ST_LWAIT;
            ST_LWAIT: begin
                if (line_req_i) begin
                    rd_left_d  = h_size_q;
                    pix_left_d = h_size_q;
                    byte_idx_d = 2'd0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (last_pop) begin
                    ycnt_d  = ycnt_inc;
                    state_d = (ycnt_inc == v_size_q) ? ST_IDLE : ST_LWAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything: drop buffered and in-flight pixels.
        if (!enable_i) begin
            state_d    = ST_IDLE;
            cnt_d      = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            inflight_d = 1'b0;
            byte_idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= ST_IDLE;
            h_size_q   <= '0;
            v_size_q   <= '0;
            ycnt_q     <= '0;
            rd_left_q  <= '0;
            pix_left_q <= '0;
            byte_idx_q <= 2'd0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_size_q   <= h_size_d;
            v_size_q   <= v_size_d;
            ycnt_q     <= ycnt_d;
            rd_left_q  <= rd_left_d;
            pix_left_q <= pix_left_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // NOTE: pixel storage is not reset; cnt_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) buf_q[wr_ptr_q] <= fifo_pixels_i;
    end

    always_comb begin
        byte_o = 8'h00;
        if (byte_valid) begin
            case (byte_idx_q)
                2'd0:    byte_o = head_pix[23:16];
                2'd1:    byte_o = head_pix[15:8];
                default: byte_o = head_pix[7:0];
            endcase
        end
    end

    assign fifo_rd_o        = rd_en;
    assign byte_valid_o     = byte_valid;
    assign pix_next_frame_o = enable_i && (state_q == ST_REQ);
    assign line_done_o      = last_pop;
    assign frame_done_o     = last_pop && (ycnt_inc == v_size_q);
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsi_pixel_fetcher.sv
// Directed bench for dsi_pixel_fetcher: a scripted pixel source answers fifo_rd_o
// and every accepted byte is compared with the known source byte sequence.
module tb_dsi_pixel_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic [11:0] h_size_i;
    logic [11:0] v_size_i;
    logic        frame_start_i;
    logic        line_req_i;
    logic        fifo_empty_i;
    logic        fifo_rd_o;
    logic [23:0] fifo_pixels_i;
    logic        pix_next_frame_o;
    logic        pix_vsync_i;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic        line_done_o;
    logic        frame_done_o;
    logic        busy_o;

    dsi_pixel_fetcher #(.g_size_width(12), .g_buf_depth(2)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .enable_i         (enable_i),
        .h_size_i         (h_size_i),
        .v_size_i         (v_size_i),
        .frame_start_i    (frame_start_i),
        .line_req_i       (line_req_i),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_rd_o        (fifo_rd_o),
        .fifo_pixels_i    (fifo_pixels_i),
        .pix_next_frame_o (pix_next_frame_o),
        .pix_vsync_i      (pix_vsync_i),
        .byte_o           (byte_o),
        .byte_valid_o     (byte_valid_o),
        .byte_ready_i     (byte_ready_i),
        .line_done_o      (line_done_o),
        .frame_done_o     (frame_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int pix_idx, exp_idx, frame_reads, max_occ;
    int line_bytes, line_reads, first_rd, first_val, fd_cnt, fd_bad, rd_empty;
    int starve_left = 0;
    bit starve_en = 0, ready_toggle = 0;
    bit pend_rd = 0, prev_stall = 0, ld_seen;
    logic [7:0] prev_byte;
    logic nf_obs, busy_obs, rd_obs, bv_obs, ld_obs, fd_obs;
    logic [7:0] bo_obs;

    // Source pattern: byte j of the stream is (j+1)*0x11 mod 256.
    function automatic logic [7:0] exp_byte(input int j);
        return 8'(((j + 1) * 17) % 256);
    endfunction

    function automatic logic [23:0] src_pix(input int k);
        return {exp_byte(3 * k), exp_byte(3 * k + 1), exp_byte(3 * k + 2)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        bit starve_last;
        int occ;
        fifo_pixels_i = pend_rd ? src_pix(pix_idx) : 24'h0BAD0B;
        if (pend_rd) pix_idx++;
        byte_ready_i  = ready_toggle ? ((cyc % 2) == 0) : 1'b1;
        starve_last   = (starve_left == 1);
        fifo_empty_i  = (starve_left > 0);
        if (starve_left > 0) starve_left--;
        #1;
        nf_obs = pix_next_frame_o; busy_obs = busy_o; rd_obs = fifo_rd_o;
        bv_obs = byte_valid_o; bo_obs = byte_o; ld_obs = line_done_o; fd_obs = frame_done_o;
        if (prev_stall) begin
            check("hold_valid", 32'(byte_valid_o), 32'd1);
            check("hold_byte", 32'(byte_o), 32'(prev_byte));
        end
        occ = frame_reads + int'(fifo_rd_o) - exp_idx / 3;
        if (occ > max_occ) max_occ = occ;
        if (byte_valid_o && first_val < 0) first_val = cyc;
        if (byte_valid_o && byte_ready_i) begin
            check("byte", 32'(byte_o), 32'(exp_byte(exp_idx)));
            exp_idx++;
            line_bytes++;
        end
        if (fifo_rd_o) begin
            line_reads++;
            frame_reads++;
            if (fifo_empty_i) rd_empty++;
            if (first_rd < 0) first_rd = cyc;
            if (starve_en && line_reads == 1) begin
                starve_left = 10;
                starve_en   = 0;
            end
        end
        if (line_done_o) ld_seen = 1;
        if (frame_done_o) fd_cnt++;
        if (frame_done_o && !line_done_o) fd_bad++;
        if (starve_last) check("starve_idle", 32'(line_bytes), 32'd3);
        pend_rd    = fifo_rd_o;
        prev_stall = byte_valid_o && !byte_ready_i;
        prev_byte  = byte_o;
        cyc++;
        @(negedge clk_i);
    endtask

    // Frame start plus the next_frame/vsync handshake, vsync returned 3 cycles late.
    task automatic handshake(input int h, input int v);
        pix_idx = 0; exp_idx = 0; frame_reads = 0; max_occ = 0; pend_rd = 0;
        h_size_i = 12'(h); v_size_i = 12'(v);
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nf_wait", 32'(nf_obs), 32'd1);
        end
        pix_vsync_i = 1'b1;
        step();
        check("nf_at_vsync", 32'(nf_obs), 32'd1);
        pix_vsync_i = 1'b0;
        step();
        check("nf_after_vsync", 32'(nf_obs), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("no_rd_before_lreq", 32'(frame_reads), 32'd0);
    endtask

    task automatic run_line(input int h, input bit is_last);
        line_bytes = 0; line_reads = 0; first_rd = -1; first_val = -1;
        ld_seen = 0; fd_cnt = 0; fd_bad = 0; rd_empty = 0;
        line_req_i = 1'b1;
        step();
        line_req_i = 1'b0;
        for (int i = 0; i < 300 && !ld_seen; i++) step();
        check("line_done", 32'(ld_seen), 32'd1);
        check("line_bytes", 32'(line_bytes), 32'(3 * h));
        check("line_reads", 32'(line_reads), 32'(h));
        check("latency", 32'(first_val - first_rd), 32'd2);
        check("frame_done", 32'(fd_cnt), 32'(is_last));
        check("fd_with_ld", 32'(fd_bad), 32'd0);
        check("rd_while_empty", 32'(rd_empty), 32'd0);
        check("max_occ_le2", 32'(max_occ <= 2), 32'd1);
        if (is_last) begin
            step();
            check("busy_fall", 32'(busy_obs), 32'd0);
        end
    endtask

    initial begin
        rst_n_i = 1'b0; enable_i = 1'b1; h_size_i = '0; v_size_i = '0;
        frame_start_i = 1'b0; line_req_i = 1'b0; fifo_empty_i = 1'b0;
        fifo_pixels_i = '0; pix_vsync_i = 1'b0; byte_ready_i = 1'b1;
        pix_idx = 0; exp_idx = 0; frame_reads = 0; max_occ = 0;
        line_bytes = 0; line_reads = 0; first_rd = -1; first_val = -1;
        fd_cnt = 0; fd_bad = 0; rd_empty = 0; ld_seen = 0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rd", 32'(fifo_rd_o), 32'd0);
        check("rst_nf", 32'(pix_next_frame_o), 32'd0);
        check("rst_valid", 32'(byte_valid_o), 32'd0);
        check("rst_byte", 32'(byte_o), 32'd0);
        check("rst_ld", 32'(line_done_o), 32'd0);
        check("rst_fd", 32'(frame_done_o), 32'd0);
        @(negedge clk_i);

        // Degenerate sizes: frame_start is ignored.
        for (int k = 0; k < 2; k++) begin
            bit nf_ever;
            nf_ever = 0;
            h_size_i = (k == 0) ? 12'd0 : 12'd4;
            v_size_i = (k == 0) ? 12'd2 : 12'd0;
            frame_start_i = 1'b1;
            step();
            frame_start_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (nf_obs) nf_ever = 1;
            end
            check("degen_busy", 32'(busy_obs), 32'd0);
            check("degen_nf", 32'(nf_ever), 32'd0);
        end

        // Basic frame, 4x2, ready held high.
        handshake(4, 2);
        run_line(4, 1'b0);
        run_line(4, 1'b1);
        check("frame_bytes", 32'(exp_idx), 32'd24);

        // Backpressure, ready toggling every cycle.
        ready_toggle = 1;
        handshake(3, 1);
        run_line(3, 1'b1);
        ready_toggle = 0;

        // Source starvation for 10 cycles after the first pixel read.
        handshake(4, 1);
        starve_en = 1;
        run_line(4, 1'b1);

        // Abort during the second pixel, then a clean new frame.
        handshake(4, 2);
        line_req_i = 1'b1;
        step();
        line_req_i = 1'b0;
        for (int i = 0; i < 100 && exp_idx < 4; i++) step();
        check("abort_reach", 32'(exp_idx), 32'd4);
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        step();
        check("abort_busy", 32'(busy_obs), 32'd0);
        check("abort_rd", 32'(rd_obs), 32'd0);
        check("abort_valid", 32'(bv_obs), 32'd0);
        check("abort_byte", 32'(bo_obs), 32'd0);
        check("abort_nf", 32'(nf_obs), 32'd0);
        check("abort_ld", 32'(ld_obs), 32'd0);
        check("abort_fd", 32'(fd_obs), 32'd0);
        handshake(2, 1);
        run_line(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
